// File: rtl/core_target_cmd_arb.sv
// Round-robin arbiter that funnels core-side target commands into the single
// target command register bank, running the "cm"/"ok" semaphore handshake with the host.
module core_target_cmd_arb #(
    parameter int          NREQ    = 4,
    parameter int unsigned TIMEOUT = 74_250_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          bridge_addr,
    input  logic                 bridge_rd,
    input  logic                 bridge_wr,
    input  logic [31:0]          bridge_wr_data,
    output logic [31:0]          bridge_rd_data,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   req_cmd,
    input  logic [32*NREQ-1:0]   req_param0,
    input  logic [32*NREQ-1:0]   req_param1,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      done,
    output logic [15:0]          result,
    output logic [31:0]          resp0,
    output logic [31:0]          resp1,
    output logic                 busy
);

    localparam int          IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0] TMAX = 32'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [15:0]     cmd_q;
    logic [31:0]     target0_q, target20_q, target24_q;
    logic [31:0]     target40_q, target44_q, target48_q, target4c_q;
    logic [31:0]     cnt_q;
    logic [IW-1:0]   lastGrant_q;
    logic [NREQ-1:0] ack_q, done_q;
    logic [15:0]     result_q;
    logic [31:0]     resp0_q, resp1_q;
    logic [31:0]     rdData_q;

    logic [15:0]     reqCmdArr   [NREQ];
    logic [31:0]     reqParam0Arr[NREQ];
    logic [31:0]     reqParam1Arr[NREQ];

    logic            hit;
    logic [7:0]      offset;
    logic [31:0]     rdMux;
    logic [IW-1:0]   grantIdx;
    logic [IW-1:0]   cand;
    logic            found;
    logic [NREQ-1:0] grantOneHot;
    logic [NREQ-1:0] ownerOneHot;
    logic            hostOk;
    logic            timedOut;
    logic            unusedAddr;

    for (genvar i = 0; i < NREQ; i++) begin : g_slices
        assign reqCmdArr[i]    = req_cmd[16*i +: 16];
        assign reqParam0Arr[i] = req_param0[32*i +: 32];
        assign reqParam1Arr[i] = req_param1[32*i +: 32];
    end

    assign hit        = (bridge_addr[31:24] == 8'hF8) && (bridge_addr[15:8] == 8'h10);
    assign offset     = bridge_addr[7:0];
    assign unusedAddr = ^bridge_addr[23:16];

    assign hostOk      = (target0_q[31:16] == 16'h6F6B);
    assign timedOut    = (cnt_q == TMAX);
    assign grantOneHot = {{(NREQ-1){1'b0}}, 1'b1} << grantIdx;
    assign ownerOneHot = {{(NREQ-1){1'b0}}, 1'b1} << lastGrant_q;

    // Round-robin search starting just past the previous winner, wrapping at NREQ.
    always_comb begin
        grantIdx = lastGrant_q;
        cand     = '0;
        found    = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(lastGrant_q) + k) % NREQ);
            if (!found && req[cand]) begin
                found    = 1'b1;
                grantIdx = cand;
            end
        end
    end

    always_comb begin
        rdMux = 32'h0;
        case (offset)
            8'h00: rdMux = target0_q;
            8'h04: rdMux = 32'h0000_0020;
            8'h08: rdMux = 32'h0000_0040;
            8'h20: rdMux = target20_q;
            8'h24: rdMux = target24_q;
            8'h40: rdMux = target40_q;
            8'h44: rdMux = target44_q;
            8'h48: rdMux = target48_q;
            8'h4C: rdMux = target4c_q;
            default: rdMux = 32'h0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (found) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (hostOk || timedOut) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Host writes are applied first so the FSM's own writes to target_0 win a collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            target0_q   <= '0;
            target20_q  <= '0;
            target24_q  <= '0;
            target40_q  <= '0;
            target44_q  <= '0;
            target48_q  <= '0;
            target4c_q  <= '0;
            cnt_q       <= '0;
            lastGrant_q <= IW'(NREQ - 1);
            ack_q       <= '0;
            done_q      <= '0;
            result_q    <= '0;
            resp0_q     <= '0;
            resp1_q     <= '0;
            rdData_q    <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= '0;
            done_q  <= '0;

            if (hit && bridge_rd) rdData_q <= rdMux;

            if (hit && bridge_wr) begin
                case (offset)
                    8'h00: target0_q  <= bridge_wr_data;
                    8'h40: target40_q <= bridge_wr_data;
                    8'h44: target44_q <= bridge_wr_data;
                    8'h48: target48_q <= bridge_wr_data;
                    8'h4C: target4c_q <= bridge_wr_data;
                    default: ;
                endcase
            end

            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        ack_q       <= grantOneHot;
                        cmd_q       <= reqCmdArr[grantIdx];
                        target20_q  <= reqParam0Arr[grantIdx];
                        target24_q  <= reqParam1Arr[grantIdx];
                        lastGrant_q <= grantIdx;
                    end
                end
                S_ISSUE: begin
                    target0_q <= {16'h636D, cmd_q};
                    cnt_q     <= '0;
                end
                S_WAIT: begin
                    // Completion outputs are registered on entry to DONE so they line up with done.
                    if (hostOk || timedOut) begin
                        result_q <= hostOk ? target0_q[15:0] : 16'hFFFE;
                        resp0_q  <= target40_q;
                        resp1_q  <= target44_q;
                        done_q   <= ownerOneHot;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_DONE: begin
                    target0_q <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bridge_rd_data = rdData_q;
    assign ack            = ack_q;
    assign done           = done_q;
    assign result         = result_q;
    assign resp0          = resp0_q;
    assign resp1          = resp1_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_core_target_cmd_arb.sv
// Directed bench for core_target_cmd_arb: single command, round-robin order,
// timeout, error passthrough, reset mid-wait and a semaphore collision.
module tb_core_target_cmd_arb;

    localparam int NREQ = 4;
    localparam logic [31:0] BASE = 32'hF800_1000;

    logic                clk;
    logic                rst;
    logic [31:0]         bridgeAddr;
    logic                bridgeRd;
    logic                bridgeWr;
    logic [31:0]         bridgeWrData;
    logic [31:0]         bridgeRdData;
    logic [NREQ-1:0]     req;
    logic [16*NREQ-1:0]  reqCmd;
    logic [32*NREQ-1:0]  reqParam0;
    logic [32*NREQ-1:0]  reqParam1;
    logic [NREQ-1:0]     ack;
    logic [NREQ-1:0]     done;
    logic [15:0]         result;
    logic [31:0]         resp0;
    logic [31:0]         resp1;
    logic                busy;

    logic [15:0] cmdArr[NREQ];
    logic [31:0] p0Arr[NREQ];
    logic [31:0] p1Arr[NREQ];

    int checks = 0;
    int errors = 0;
    logic [NREQ-1:0] ackDuringWait;
    logic [NREQ-1:0] doneSeen;
    logic [31:0] rdVal;
    int n;

    assign reqCmd    = {cmdArr[3], cmdArr[2], cmdArr[1], cmdArr[0]};
    assign reqParam0 = {p0Arr[3], p0Arr[2], p0Arr[1], p0Arr[0]};
    assign reqParam1 = {p1Arr[3], p1Arr[2], p1Arr[1], p1Arr[0]};

    core_target_cmd_arb #(.NREQ(NREQ), .TIMEOUT(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .bridge_addr    (bridgeAddr),
        .bridge_rd      (bridgeRd),
        .bridge_wr      (bridgeWr),
        .bridge_wr_data (bridgeWrData),
        .bridge_rd_data (bridgeRdData),
        .req            (req),
        .req_cmd        (reqCmd),
        .req_param0     (reqParam0),
        .req_param1     (reqParam1),
        .ack            (ack),
        .done           (done),
        .result         (result),
        .resp0          (resp0),
        .resp1          (resp1),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] reqVal);
        req = reqVal;
    endtask

    task automatic busWrite(input logic [7:0] off, input logic [31:0] data);
        bridgeAddr   = BASE | {24'h0, off};
        bridgeWrData = data;
        bridgeWr     = 1'b1;
        tick();
        bridgeWr     = 1'b0;
    endtask

    task automatic busReadAddr(input logic [31:0] addr, output logic [31:0] data);
        bridgeAddr = addr;
        bridgeRd   = 1'b1;
        tick();
        bridgeRd   = 1'b0;
        data       = bridgeRdData;
    endtask

    task automatic busRead(input logic [7:0] off, output logic [31:0] data);
        busReadAddr(BASE | {24'h0, off}, data);
    endtask

    task automatic busRdWr(input logic [7:0] off, input logic [31:0] wdata, output logic [31:0] data);
        bridgeAddr   = BASE | {24'h0, off};
        bridgeWrData = wdata;
        bridgeRd     = 1'b1;
        bridgeWr     = 1'b1;
        tick();
        bridgeRd     = 1'b0;
        bridgeWr     = 1'b0;
        data         = bridgeRdData;
    endtask

    task automatic waitAck(input logic [NREQ-1:0] expAck, input string tag);
        int cnt = 0;
        do begin
            tick();
            cnt++;
        end while (ack == '0 && cnt < 30);
        checkOutput(tag, 32'(ack), 32'(expAck));
    endtask

    task automatic waitDone(input logic [NREQ-1:0] expDone, input string tag);
        int cnt = 0;
        do begin
            tick();
            cnt++;
            ackDuringWait |= ack;
        end while (done == '0 && cnt < 40);
        checkOutput(tag, 32'(done), 32'(expDone));
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; bridgeAddr = '0; bridgeRd = 1'b0; bridgeWr = 1'b0; bridgeWrData = '0;
        ackDuringWait = '0; doneSeen = '0;
        for (int i = 0; i < NREQ; i++) begin
            cmdArr[i] = '0; p0Arr[i] = '0; p1Arr[i] = '0;
        end
        tick();
        tick();
        checkOutput("rst_ack", 32'(ack), 32'h0);
        checkOutput("rst_done", 32'(done), 32'h0);
        checkOutput("rst_result", 32'(result), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_rddata", bridgeRdData, 32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] single request");
        cmdArr[1] = 16'h0140; p0Arr[1] = 32'h1234_5678; p1Arr[1] = 32'hCAFE_F00D;
        applyStimulus(4'b0010);
        waitAck(4'b0010, "single_ack");
        checkOutput("single_busy", 32'(busy), 32'h1);
        applyStimulus(4'b0000);
        tick();
        busRead(8'h00, rdVal);
        checkOutput("single_sem", rdVal, 32'h636D_0140);
        busRead(8'h20, rdVal);
        checkOutput("single_p0", rdVal, 32'h1234_5678);
        busRead(8'h24, rdVal);
        checkOutput("single_p1", rdVal, 32'hCAFE_F00D);
        busWrite(8'h40, 32'h0000_00AA);
        busWrite(8'h00, 32'h6F6B_0000);
        waitDone(4'b0010, "single_done");
        checkOutput("single_result", 32'(result), 32'h0);
        checkOutput("single_resp0", resp0, 32'h0000_00AA);
        checkOutput("single_resp1", resp1, 32'h0);
        tick();
        checkOutput("single_busy_fall", 32'(busy), 32'h0);
        checkOutput("single_done_pulse", 32'(done), 32'h0);
        busRead(8'h00, rdVal);
        checkOutput("single_t0_clear", rdVal, 32'h0);

        $display("[TB] round robin");
        doReset();
        applyStimulus(4'b1011);
        for (int i = 0; i < 6; i++) begin
            logic [NREQ-1:0] exp;
            case (i % 3)
                0: exp = 4'b0001;
                1: exp = 4'b0010;
                default: exp = 4'b1000;
            endcase
            waitAck(exp, "rr_ack");
            tick();
            busWrite(8'h00, 32'h6F6B_0000);
            waitDone(exp, "rr_done");
        end
        applyStimulus(4'b0000);
        checkOutput("rr_no_early_ack", 32'(ackDuringWait), 32'h0);

        $display("[TB] timeout");
        applyStimulus(4'b0100);
        waitAck(4'b0100, "to_ack");
        applyStimulus(4'b0000);
        n = 0;
        do begin
            tick();
            n++;
        end while (done == '0 && n < 40);
        checkOutput("to_latency", 32'(n), 32'd17);
        checkOutput("to_done", 32'(done), 32'(4'b0100));
        checkOutput("to_result", 32'(result), 32'h0000_FFFE);
        tick();
        busRead(8'h00, rdVal);
        checkOutput("to_t0_clear", rdVal, 32'h0);

        $display("[TB] error code passthrough");
        cmdArr[0] = 16'h0007;
        applyStimulus(4'b0001);
        waitAck(4'b0001, "err_ack");
        applyStimulus(4'b0000);
        tick();
        busWrite(8'h40, 32'h0000_0055);
        busWrite(8'h00, 32'h6F6B_0002);
        waitDone(4'b0001, "err_done");
        checkOutput("err_result", 32'(result), 32'h0000_0002);
        checkOutput("err_resp0", resp0, 32'h0000_0055);
        busRead(8'h04, rdVal);
        checkOutput("const_04", rdVal, 32'h0000_0020);
        busRead(8'h08, rdVal);
        checkOutput("const_08", rdVal, 32'h0000_0040);
        busWrite(8'h04, 32'hDEAD_BEEF);
        busRead(8'h04, rdVal);
        checkOutput("const_04_ro", rdVal, 32'h0000_0020);
        busReadAddr(32'hF800_2008, rdVal);
        checkOutput("nohit_hold", rdVal, 32'h0000_0020);
        busRead(8'h30, rdVal);
        checkOutput("unmapped_zero", rdVal, 32'h0);
        busRdWr(8'h40, 32'h0000_0077, rdVal);
        checkOutput("rdwr_old", rdVal, 32'h0000_0055);
        busRead(8'h40, rdVal);
        checkOutput("rdwr_new", rdVal, 32'h0000_0077);
        checkOutput("resp0_held", resp0, 32'h0000_0055);

        $display("[TB] reset mid-wait");
        applyStimulus(4'b0100);
        waitAck(4'b0100, "mid_ack");
        applyStimulus(4'b0000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_ack_zero", 32'(ack), 32'h0);
        checkOutput("mid_done_zero", 32'(done), 32'h0);
        checkOutput("mid_result_zero", 32'(result), 32'h0);
        checkOutput("mid_resp0_zero", resp0, 32'h0);
        checkOutput("mid_busy_zero", 32'(busy), 32'h0);
        checkOutput("mid_rddata_zero", bridgeRdData, 32'h0);
        doneSeen = '0;
        for (int i = 0; i < 25; i++) begin
            tick();
            doneSeen |= done;
        end
        checkOutput("mid_no_done", 32'(doneSeen), 32'h0);
        busRead(8'h00, rdVal);
        checkOutput("mid_t0_zero", rdVal, 32'h0);

        $display("[TB] collision");
        cmdArr[0] = 16'h0033;
        applyStimulus(4'b1111);
        waitAck(4'b0001, "post_rst_first");
        applyStimulus(4'b0000);
        busWrite(8'h00, 32'h6F6B_0001);
        busRead(8'h00, rdVal);
        checkOutput("col_sem_wins", rdVal, 32'h636D_0033);
        checkOutput("col_busy", 32'(busy), 32'h1);
        doneSeen = '0;
        for (int i = 0; i < 5; i++) begin
            tick();
            doneSeen |= done;
        end
        checkOutput("col_still_wait", 32'(doneSeen), 32'h0);
        busWrite(8'h00, 32'h6F6B_0000);
        waitDone(4'b0001, "col_done");
        checkOutput("col_result", 32'(result), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
